rf_frame_scheduler: RTL and testbench
=====================================

RF_FRAME_SCHEDULER -- requirements
Module: rf_frame_scheduler

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 8333334, clocks per serial bit (minimum 2).
REQ-002 SHALL have parameter SYNC_BYTE, default 8'hFF, the first byte of every frame.
REQ-003 SHALL have port Clk, input, 1, the single system clock; all logic is on the rising edge.
REQ-004 SHALL have port Rst, input, 1, a synchronous, active-high reset.
REQ-005 SHALL have ports Req_A/Req_B, input, 1 each, transmit requests from source A (ADC) and source B (auxiliary).
REQ-006 SHALL have ports Data_A/Data_B, input, 8 each, the payload bytes; each is stable while its Req is high.
REQ-007 SHALL have ports Ack_A/Ack_B, output, 1 each, one-cycle grant pulses.
REQ-008 SHALL have port Hold, output, 1, high while the granted payload is in flight.
REQ-009 SHALL have port Serial_Bit_Out, output, 1, the RF serial line; idle level is 1.
REQ-010 SHALL have ports Busy (output, 1, high from grant to frame end) and Frame_Done (output, 1, one-cycle pulse at frame end).

Function
REQ-011 SHALL sample Req_A/Req_B only in IDLE; a Req that drops before being sampled produces no frame and no Ack.
REQ-012 SHALL arbitrate round-robin: if both requests are high, the source not served last wins; after reset A has priority.
REQ-013 SHALL, in the cycle after a request is sampled, pulse the winner's Ack for exactly one cycle, latch its Data and channel ID (A=8'h00, B=8'h01), and raise Busy and Hold.
REQ-014 SHALL use the states IDLE -> SEND_SYNC -> SEND_ID -> SEND_DATA -> [SEND_CSUM] -> IDLE.
REQ-015 SHALL send each byte as one start bit (0), 8 data bits LSB first, and one stop bit (1), i.e. 10 bit periods.
REQ-016 SHALL make every bit last exactly CLKS_PER_BIT clocks; the start bit of SYNC begins in the cycle after Ack.
REQ-017 SHALL re-zero the bit-timing counter on the grant, so no partial first bit occurs.
REQ-018 SHALL drop Hold in the cycle after the SEND_DATA stop bit completes.
REQ-019 SHALL pulse Frame_Done in the last cycle of the final stop bit, drop Busy, and return to IDLE on the next edge.
REQ-020 SHALL grant the next frame no earlier than the first IDLE cycle; frames are never back-to-back without one idle cycle.
REQ-021 SHALL hold Serial_Bit_Out at 1 in IDLE.
REQ-022 SHALL ignore Req changes during a frame; a Req still held high at IDLE is then arbitrated normally.

Reset
REQ-023 SHALL on Rst=1 force: state IDLE, Serial_Bit_Out=1, Ack_A=Ack_B=0, Hold=0, Busy=0, Frame_Done=0, bit counter 0, round-robin pointer set to favor A.
REQ-024 SHALL, on reset during a frame, abort the frame, return the line to 1 on the next edge, and never retransmit the aborted frame.

Configuration
REQ-025 SHALL, with macro RF_FRAME_CHECKSUM_EN defined, append SEND_CSUM with byte (CH_ID + DATA) mod 256, giving a 40-bit frame.
REQ-026 SHALL, without RF_FRAME_CHECKSUM_EN, omit SEND_CSUM and go to IDLE after SEND_DATA, giving a 30-bit frame.

Structure
REQ-027 SHALL take from shared package rf_link_pkg: the state encoding, default SYNC_BYTE, the channel ID constants, and BITS_PER_BYTE=10.
REQ-028 SHALL instantiate one sub-module, baud_tick (counter with sync clear, one-cycle tick every CLKS_PER_BIT clocks); the bit/byte sequencing stays in rf_frame_scheduler.

Verification (CLKS_PER_BIT=4 unless stated)
REQ-029 SHALL cover: Req_A=1, Data_A=8'h5A -> Ack_A pulse next cycle; the line shows bytes FF,00,5A framed 0/LSB-first/1; each bit lasts 4 clocks; Frame_Done at clock 120 after Ack (160 with checksum, CSUM=8'h5A).
REQ-030 SHALL cover: Req_A and Req_B high together after reset -> A served first, then B (ID 8'h01) after one IDLE cycle; with both held, the service order alternates A,B,A,B.
REQ-031 SHALL cover: Req_B=1, Data_B=8'hFF, checksum enabled -> CSUM byte 8'h00 (0x01+0xFF wraps).
REQ-032 SHALL cover: Rst asserted at bit 15 of a frame -> next edge Serial_Bit_Out=1, Busy=0, Hold=0; no Frame_Done; no retransmission after Rst drops.
REQ-033 SHALL cover: Req_A pulsed high for 1 cycle while Busy -> no Ack_A and no extra frame.
REQ-034 SHALL cover: Hold high from the cycle after Ack through the DATA stop bit, then low during CSUM; CLKS_PER_BIT=2 boundary -> 2-clock bits.

Source files
------------

// File: rtl/rf_link_pkg.sv
// Shared definitions for the RF serial link: frame state encoding, default
// sync byte, channel IDs and the per-byte bit count.
package rf_link_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SEND_SYNC,
    ST_SEND_ID,
    ST_SEND_DATA,
    ST_SEND_CSUM
  } rf_state_t;

  localparam logic [7:0]  RF_SYNC_BYTE  = 8'hFF;
  localparam logic [7:0]  RF_CH_ID_A    = 8'h00;
  localparam logic [7:0]  RF_CH_ID_B    = 8'h01;
  localparam int unsigned BITS_PER_BYTE = 10;

  // Frame checksum: channel ID plus payload, wrapping at 256.
  function automatic logic [7:0] rf_csum(input logic [7:0] ch_id, input logic [7:0] data);
    return ch_id + data;
  endfunction

endpackage

// File: rtl/baud_tick.sv
// Bit-period timer: free-running counter with synchronous clear that emits a
// one-cycle Tick in the last clock of every CLKS_PER_BIT-clock period.
module baud_tick #(
  parameter int unsigned CLKS_PER_BIT = 8333334
) (
  input  logic Clk,
  input  logic Clr,
  output logic Tick
);

  localparam int unsigned CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] cnt_q;

  // Count clocks within a bit period; Clr pins the count to zero.
  always_ff @(posedge Clk) begin
    if (Clr) begin
      cnt_q <= '0;
    end else if (cnt_q == LAST) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign Tick = !Clr && (cnt_q == LAST);

endmodule

// File: rtl/rf_frame_scheduler.sv
// RF frame scheduler: round-robin arbitration between two byte sources and
// UART-style framing (start, 8 data LSB first, stop) of SYNC, ID, DATA and,
// when RF_FRAME_CHECKSUM_EN is defined, a trailing checksum byte.
module rf_frame_scheduler
  import rf_link_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 8333334,
  parameter logic [7:0]  SYNC_BYTE    = RF_SYNC_BYTE
) (
  input  logic       Clk,
  input  logic       Rst,
  input  logic       Req_A,
  input  logic       Req_B,
  input  logic [7:0] Data_A,
  input  logic [7:0] Data_B,
  output logic       Ack_A,
  output logic       Ack_B,
  output logic       Hold,
  output logic       Serial_Bit_Out,
  output logic       Busy,
  output logic       Frame_Done
);

  localparam logic [3:0] LAST_BIT = 4'(BITS_PER_BYTE - 1);

  rf_state_t  state_q, state_d;
  logic       arm_q;       // Ack cycle: frame granted, line not yet started
  logic [3:0] bit_q;
  logic [7:0] data_q;
  logic [7:0] ch_q;
  logic       last_a_q;
  logic       hold_q;
  logic       ack_a_q, ack_b_q;

  logic       tick;
  logic       baud_clr;
  logic       grant_a, grant_b;
  logic       end_of_byte;
  logic       done;
  logic [7:0] cur_byte;
  logic [2:0] dsel;
  logic       ser;

  // Timer held at zero while idle and during the Ack cycle so the first bit
  // of SYNC is a full period.
  assign baud_clr = Rst || (state_q == ST_IDLE) || arm_q;

  baud_tick #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .Clk  (Clk),
    .Clr  (baud_clr),
    .Tick (tick)
  );

  // State register.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Arbitration, next-state and line-level decode.
  always_comb begin
    state_d     = state_q;
    grant_a     = 1'b0;
    grant_b     = 1'b0;
    done        = 1'b0;
    end_of_byte = tick && !arm_q && (bit_q == LAST_BIT);
    cur_byte    = '1;
    ser         = 1'b1;
    dsel        = 3'(bit_q - 4'd1);

    case (state_q)
      ST_IDLE: begin
        if (Req_A && Req_B) begin
          grant_a = !last_a_q;
          grant_b = last_a_q;
        end else begin
          grant_a = Req_A;
          grant_b = Req_B;
        end
        if (grant_a || grant_b) state_d = ST_SEND_SYNC;
      end
      ST_SEND_SYNC: begin
        cur_byte = SYNC_BYTE;
        if (end_of_byte) state_d = ST_SEND_ID;
      end
      ST_SEND_ID: begin
        cur_byte = ch_q;
        if (end_of_byte) state_d = ST_SEND_DATA;
      end
      ST_SEND_DATA: begin
        cur_byte = data_q;
        if (end_of_byte) begin
`ifdef RF_FRAME_CHECKSUM_EN
          state_d = ST_SEND_CSUM;
`else
          state_d = ST_IDLE;
          done    = 1'b1;
`endif
        end
      end
      ST_SEND_CSUM: begin
        cur_byte = rf_csum(ch_q, data_q);
        if (end_of_byte) begin
          state_d = ST_IDLE;
          done    = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if ((state_q != ST_IDLE) && !arm_q) begin
      if (bit_q == 4'd0) begin
        ser = 1'b0;
      end else if (bit_q <= 4'd8) begin
        ser = cur_byte[dsel];
      end else begin
        ser = 1'b1;
      end
    end
  end

  // Grant capture, bit sequencing, Hold and Ack pulses.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      arm_q    <= 1'b0;
      bit_q    <= '0;
      data_q   <= '0;
      ch_q     <= '0;
      last_a_q <= 1'b0;
      hold_q   <= 1'b0;
      ack_a_q  <= 1'b0;
      ack_b_q  <= 1'b0;
    end else begin
      ack_a_q <= grant_a;
      ack_b_q <= grant_b;
      if (grant_a || grant_b) begin
        data_q   <= grant_a ? Data_A : Data_B;
        ch_q     <= grant_a ? RF_CH_ID_A : RF_CH_ID_B;
        last_a_q <= grant_a;
        arm_q    <= 1'b1;
        hold_q   <= 1'b1;
        bit_q    <= '0;
      end else begin
        arm_q <= 1'b0;
        if (tick && !arm_q) begin
          bit_q <= (bit_q == LAST_BIT) ? 4'd0 : bit_q + 4'd1;
        end
        if (end_of_byte && (state_q == ST_SEND_DATA)) begin
          hold_q <= 1'b0;
        end
      end
    end
  end

  assign Ack_A          = ack_a_q;
  assign Ack_B          = ack_b_q;
  assign Hold           = hold_q;
  assign Busy           = (state_q != ST_IDLE);
  assign Frame_Done     = done;
  assign Serial_Bit_Out = ser;

endmodule

// File: tb/tb_rf_frame_scheduler.sv
// Bench for rf_frame_scheduler: two instances (4 and 2 clocks per bit),
// scoreboard of expected grants, per-instance frame monitor.
// Honors RF_FRAME_CHECKSUM_EN for the expected frame length and CSUM byte.
module tb_rf_frame_scheduler;

`ifdef RF_FRAME_CHECKSUM_EN
  localparam int NB = 4;
`else
  localparam int NB = 3;
`endif

  typedef struct {
    int         d;
    bit         src_b;
    logic [7:0] data;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] req_a, req_b;
  logic [7:0] data_a [2];
  logic [7:0] data_b [2];
  logic [1:0] ack_a, ack_b, hold, ser, busy, done;

  exp_t sb[$];
  int   tests = 0;
  int   fails = 0;
  bit   mon_act [2];

  always #5 clk = ~clk;

  rf_frame_scheduler #(.CLKS_PER_BIT(4)) dut (
    .Clk(clk), .Rst(rst), .Req_A(req_a[0]), .Req_B(req_b[0]),
    .Data_A(data_a[0]), .Data_B(data_b[0]), .Ack_A(ack_a[0]), .Ack_B(ack_b[0]),
    .Hold(hold[0]), .Serial_Bit_Out(ser[0]), .Busy(busy[0]), .Frame_Done(done[0])
  );

  rf_frame_scheduler #(.CLKS_PER_BIT(2)) dut2 (
    .Clk(clk), .Rst(rst), .Req_A(req_a[1]), .Req_B(req_b[1]),
    .Data_A(data_a[1]), .Data_B(data_b[1]), .Ack_A(ack_a[1]), .Ack_B(ack_b[1]),
    .Hold(hold[1]), .Serial_Bit_Out(ser[1]), .Busy(busy[1]), .Frame_Done(done[1])
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Watches one instance: every Ack pops an expected grant and the whole
  // frame is checked bit by bit against it.
  task automatic frame_mon(input int d, input int cpb);
    exp_t       e;
    logic [7:0] bytes [4];
    logic [9:0] vf [4];
    logic [9:0] vl [4];
    logic [9:0] fr;
    int         hold_err, done_err, busy_err, nclk;
    bit         aborted;
    forever begin
      @(negedge clk);
      if (!rst && (ack_a[d] || ack_b[d])) begin
        mon_act[d] = 1'b1;
        if (sb.size() == 0) begin
          check("unexp_ack", {30'd0, ack_a[d], ack_b[d]}, 32'd0);
        end else begin
          e = sb.pop_front();
          check("ack_src", {30'd0, ack_a[d], ack_b[d]}, e.src_b ? 32'd1 : 32'd2);
          check("ack_dut", d, e.d);
          check("ack_cycle_hold_busy_line", {29'd0, hold[d], busy[d], ser[d]}, 32'd7);
          bytes[0] = 8'hFF;
          bytes[1] = e.src_b ? 8'h01 : 8'h00;
          bytes[2] = e.data;
          bytes[3] = bytes[1] + bytes[2];
          nclk     = NB * 10 * cpb;
          hold_err = 0;
          done_err = 0;
          busy_err = 0;
          aborted  = 1'b0;
          for (int c = 1; c <= nclk && !aborted; c++) begin
            @(negedge clk);
            if (rst) begin
              aborted = 1'b1;
            end else begin
              int bi, ph;
              bi = (c - 1) / cpb;
              ph = (c - 1) % cpb;
              if (ph == 0)       vf[bi / 10][bi % 10] = ser[d];
              if (ph == cpb - 1) vl[bi / 10][bi % 10] = ser[d];
              if (hold[d] !== (c <= 30 * cpb)) hold_err++;
              if (done[d] !== (c == nclk)) done_err++;
              if (busy[d] !== 1'b1 || ack_a[d] || ack_b[d]) busy_err++;
            end
          end
          if (aborted) begin
            @(negedge clk);
            check("abort_outputs", {28'd0, ser[d], busy[d], hold[d], done[d]}, 32'h8);
          end else begin
            for (int b = 0; b < NB; b++) begin
              fr = {1'b1, bytes[b], 1'b0};
              check("bit_first_clk", {22'd0, vf[b]}, {22'd0, fr});
              check("bit_last_clk", {22'd0, vl[b]}, {22'd0, fr});
            end
            check("hold_window", hold_err, 0);
            check("done_position", done_err, 0);
            check("busy_window", busy_err, 0);
            @(negedge clk);
            check("idle_after_frame", {28'd0, busy[d], ser[d], hold[d], done[d]}, 32'h4);
          end
        end
        mon_act[d] = 1'b0;
      end
    end
  endtask

  task automatic single(input int d, input bit src_b, input logic [7:0] data);
    int  k;
    exp_t e;
    e.d = d; e.src_b = src_b; e.data = data;
    sb.push_back(e);
    if (src_b) begin data_b[d] = data; req_b[d] = 1'b1; end
    else       begin data_a[d] = data; req_a[d] = 1'b1; end
    for (k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (ack_a[d] || ack_b[d]) break;
    end
    check("ack_latency", k, 1);
    req_a[d] = 1'b0;
    req_b[d] = 1'b0;
  endtask

  task automatic wait_idle(input int d);
    bit timed_out = 1'b1;
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      if (sb.size() == 0 && !mon_act[d] && !busy[d]) begin
        timed_out = 1'b0;
        break;
      end
    end
    check("wait_idle_timeout", {31'd0, timed_out}, 32'd0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    fork
      frame_mon(0, 4);
      frame_mon(1, 2);
    join_none
  end

  initial begin
    int n, cnt;
    int t [4];
    exp_t e;
    rst   = 1'b1;
    req_a = '0;
    req_b = '0;
    for (int d = 0; d < 2; d++) begin
      data_a[d] = '0;
      data_b[d] = '0;
      mon_act[d] = 1'b0;
    end
    repeat (3) @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      check("reset_line", {31'd0, ser[d]}, 32'd1);
      check("reset_outputs", {27'd0, busy[d], hold[d], done[d], ack_a[d], ack_b[d]}, 32'd0);
    end
    rst = 1'b0;
    @(negedge clk);

    // Basic frame from A, then checksum wrap case from B.
    single(0, 1'b0, 8'h5A);
    wait_idle(0);
    single(0, 1'b1, 8'hFF);
    wait_idle(0);

    // Both requesting after reset: A first, then alternating.
    do_reset();
    data_a[0] = 8'h11;
    data_b[0] = 8'h22;
    for (int i = 0; i < 4; i++) begin
      e.d = 0; e.src_b = i[0]; e.data = i[0] ? 8'h22 : 8'h11;
      sb.push_back(e);
    end
    req_a[0] = 1'b1;
    req_b[0] = 1'b1;
    n = 0;
    for (int i = 0; i < 3000 && n < 4; i++) begin
      @(negedge clk);
      if (ack_a[0] || ack_b[0]) begin
        t[n] = i;
        n++;
        if (n == 4) begin
          req_a[0] = 1'b0;
          req_b[0] = 1'b0;
        end
      end
    end
    check("rr_grant_count", n, 4);
    check("rr_ack_spacing", t[1] - t[0], NB * 10 * 4 + 2);
    wait_idle(0);

    // Reset in bit 15 aborts the frame with no retransmission.
    single(0, 1'b0, 8'h3C);
    repeat (62) @(negedge clk);
    do_reset();
    cnt = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      cnt += int'(ack_a[0]) + int'(ack_b[0]) + int'(done[0]) + int'(busy[0]);
    end
    check("no_retransmit", cnt, 0);
    check("sb_empty_after_abort", sb.size(), 0);

    // One-cycle Req_A pulse during a frame is ignored.
    single(0, 1'b1, 8'h77);
    repeat (20) @(negedge clk);
    req_a[0] = 1'b1;
    @(negedge clk);
    req_a[0] = 1'b0;
    cnt = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      cnt += int'(ack_a[0]);
    end
    check("pulse_while_busy_no_ack", cnt, 0);
    wait_idle(0);

    // Two-clock bit periods.
    single(1, 1'b0, 8'hA5);
    wait_idle(1);
    single(1, 1'b1, 8'h3C);
    wait_idle(1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
